// File: rtl/mem_resp_queue_pkg.sv
// Shared load-op encodings and per-entry metadata layout for the MEM response queue.
package mem_resp_queue_pkg;

   localparam int LD_OP_W   = 3;
   localparam int LOWBITS_W = 2;

   typedef enum logic [LD_OP_W-1:0] {
      LD_NONE = 3'd0,
      LD_W    = 3'd1,
      LD_B    = 3'd2,
      LD_BU   = 3'd3,
      LD_H    = 3'd4,
      LD_HU   = 3'd5
   } ld_op_e;

   typedef struct packed {
      logic                 is_mem;
      logic [LD_OP_W-1:0]   ld_op;
      logic [LOWBITS_W-1:0] lowbits;
      logic                 we;
      logic                 done;
   } entry_meta_t;

endpackage

// File: rtl/mem_load_extract.sv
// Byte/half lane select with sign or zero extension for ld.b/bu/h/hu/w responses.
module mem_load_extract
   import mem_resp_queue_pkg::*;
#(
   parameter int DATA_W = 32
)
(
   input  logic [DATA_W-1:0]    rdata,
   input  logic [LOWBITS_W-1:0] lowbits,
   input  logic [LD_OP_W-1:0]   ld_op,
   output logic [DATA_W-1:0]    result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Half lane follows lowbits[1] only; misalignment is trapped before EX.
   assign byte_sel = rdata[{lowbits, 3'b000} +: 8];
   assign half_sel = rdata[{lowbits[1], 4'b0000} +: 16];

   always_comb begin
      result = rdata;
      case (ld_op)
         LD_B:    result = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
         LD_BU:   result = {{(DATA_W-8){1'b0}}, byte_sel};
         LD_H:    result = {{(DATA_W-16){half_sel[15]}}, half_sel};
         LD_HU:   result = {{(DATA_W-16){1'b0}}, half_sel};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/mem_resp_queue.sv
// In-order MEM-stage queue matching bus responses to ops; optional bypass port
// presenting the youngest entry is enabled with the MEM_FWD_EN macro.
module mem_resp_queue
   import mem_resp_queue_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 32,
   parameter int DEST_W = 5,
   parameter int PC_W   = 32
)
(
   input  logic              clk,
   input  logic              resetn,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_is_mem,
   input  logic [2:0]        in_ld_op,
   input  logic [1:0]        in_lowbits,
   input  logic              in_we,
   input  logic [DEST_W-1:0] in_dest,
   input  logic [DATA_W-1:0] in_alu,
   input  logic [PC_W-1:0]   in_pc,
   input  logic              data_ok,
   input  logic [DATA_W-1:0] rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_we,
   output logic [DEST_W-1:0] out_dest,
   output logic [DATA_W-1:0] out_result,
   output logic [PC_W-1:0]   out_pc,
   output logic              req_allow,
   output logic              proto_err
`ifdef MEM_FWD_EN
   ,
   output logic              fwd_valid,
   output logic              fwd_we,
   output logic [DEST_W-1:0] fwd_dest,
   output logic [DATA_W-1:0] fwd_result,
   output logic              fwd_block
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]  count_reg, discard_cnt_reg;
   logic              proto_err_reg;

   entry_meta_t       meta_arr  [DEPTH];
   logic [DEST_W-1:0] dest_arr  [DEPTH];
   logic [DATA_W-1:0] alu_arr   [DEPTH];
   logic [PC_W-1:0]   pc_arr    [DEPTH];
   logic [DATA_W-1:0] rdata_arr [DEPTH];

   logic              full, push, pop;
   logic              to_discard, to_entry, proto_hit, consumed;
   logic [CNT_W-1:0]  awaiting;
   logic              resp_found;
   logic [PTR_W-1:0]  resp_idx;
   logic [DATA_W-1:0] head_ext;

   // Oldest mem op still waiting is the in-order target of the next data_ok.
   always_comb begin
      logic [PTR_W-1:0] idx;
      awaiting   = '0;
      resp_found = 1'b0;
      resp_idx   = rd_ptr_reg;
      idx        = rd_ptr_reg;
      for (int k = 0; k < DEPTH; k++) begin
         idx = rd_ptr_reg + PTR_W'(k);
         if ((CNT_W'(k) < count_reg) && meta_arr[idx].is_mem && !meta_arr[idx].done) begin
            awaiting = awaiting + CNT_W'(1);
            if (!resp_found) begin
               resp_found = 1'b1;
               resp_idx   = idx;
            end
         end
      end
   end

   assign full       = (count_reg == CNT_W'(DEPTH));
   assign in_ready   = !full;
   assign req_allow  = !full &&
                       (({1'b0, awaiting} + {1'b0, discard_cnt_reg}) < (CNT_W+1)'(DEPTH));
   assign push       = in_valid && in_ready && !flush;
   assign out_valid  = (count_reg != '0) && meta_arr[rd_ptr_reg].done;
   assign pop        = out_valid && out_ready;

   assign to_discard = data_ok && (discard_cnt_reg != '0);
   assign to_entry   = data_ok && (discard_cnt_reg == '0) && resp_found;
   assign proto_hit  = data_ok && (discard_cnt_reg == '0) && !resp_found;
   assign consumed   = to_discard || to_entry;
   assign proto_err  = proto_err_reg;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
         count_reg       <= '0;
         discard_cnt_reg <= '0;
         proto_err_reg   <= 1'b0;
      end else begin
         if (proto_hit) proto_err_reg <= 1'b1;
         if (flush) begin
            // Every response still owed to a killed entry must be swallowed later.
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            discard_cnt_reg <= discard_cnt_reg + awaiting - CNT_W'(consumed);
         end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
               2'b10:   count_reg <= count_reg + CNT_W'(1);
               2'b01:   count_reg <= count_reg - CNT_W'(1);
               default: count_reg <= count_reg;
            endcase
            if (to_discard) discard_cnt_reg <= discard_cnt_reg - CNT_W'(1);
         end
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      entry_meta_t       meta_reg;
      logic [DEST_W-1:0] dest_reg;
      logic [DATA_W-1:0] alu_reg;
      logic [PC_W-1:0]   pc_reg;
      logic [DATA_W-1:0] rdata_reg;

      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            meta_reg  <= '0;
            dest_reg  <= '0;
            alu_reg   <= '0;
            pc_reg    <= '0;
            rdata_reg <= '0;
         end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
            meta_reg  <= '{is_mem: in_is_mem, ld_op: in_ld_op, lowbits: in_lowbits,
                           we: in_we, done: !in_is_mem};
            dest_reg  <= in_dest;
            alu_reg   <= in_alu;
            pc_reg    <= in_pc;
         end else if (to_entry && (resp_idx == PTR_W'(gi))) begin
            meta_reg.done <= 1'b1;
            rdata_reg     <= rdata;
         end
      end

      assign meta_arr[gi]  = meta_reg;
      assign dest_arr[gi]  = dest_reg;
      assign alu_arr[gi]   = alu_reg;
      assign pc_arr[gi]    = pc_reg;
      assign rdata_arr[gi] = rdata_reg;
   end

   mem_load_extract #(.DATA_W(DATA_W)) u_head_extract (
      .rdata   (rdata_arr[rd_ptr_reg]),
      .lowbits (meta_arr[rd_ptr_reg].lowbits),
      .ld_op   (meta_arr[rd_ptr_reg].ld_op),
      .result  (head_ext)
   );

   assign out_we     = meta_arr[rd_ptr_reg].we;
   assign out_dest   = dest_arr[rd_ptr_reg];
   assign out_pc     = pc_arr[rd_ptr_reg];
   assign out_result = (meta_arr[rd_ptr_reg].ld_op == LD_NONE) ? alu_arr[rd_ptr_reg] : head_ext;

`ifdef MEM_FWD_EN
   logic [PTR_W-1:0]  tail_idx;
   logic [DATA_W-1:0] tail_ext;

   assign tail_idx = wr_ptr_reg - PTR_W'(1);

   mem_load_extract #(.DATA_W(DATA_W)) u_tail_extract (
      .rdata   (rdata_arr[tail_idx]),
      .lowbits (meta_arr[tail_idx].lowbits),
      .ld_op   (meta_arr[tail_idx].ld_op),
      .result  (tail_ext)
   );

   assign fwd_valid  = (count_reg != '0);
   assign fwd_we     = meta_arr[tail_idx].we;
   assign fwd_dest   = dest_arr[tail_idx];
   assign fwd_result = (meta_arr[tail_idx].ld_op == LD_NONE) ? alu_arr[tail_idx] : tail_ext;
   assign fwd_block  = fwd_valid && (meta_arr[tail_idx].ld_op != LD_NONE) &&
                       !meta_arr[tail_idx].done;
`endif

endmodule
